// File: rtl/muluint_accum.sv
// Accumulates a batch of COUNT unsigned products into an ACC_WIDTH-bit sum.
// The finished sum is held on a valid/ready output until the consumer takes it.
module muluint_accum #(
    parameter int DATA_WIDTH = 10,
    parameter int COUNT      = 4,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+4,
    localparam int CW        = $clog2(COUNT+1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [2*DATA_WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [ACC_WIDTH-1:0]    sum_o,
    output logic                    sum_valid_o,
    input  logic                    sum_ready_i,
    output logic                    overflow_o,
    output logic [CW-1:0]           count_o,
    output logic                    busy_o,
    output logic [1:0]              o_state
);

    // Handshakes: a word moves on an edge where valid && ready are both high.
    // in_valid/in_ready carries products in; sum_valid_o/sum_ready_i carries the sum out.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(COUNT-1);

    state_t                 r_state;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [ACC_WIDTH-1:0]   r_sum;
    logic                   r_sum_valid;
    logic                   r_ovf;
    logic [CW-1:0]          r_count;
    logic [ACC_WIDTH:0]     w_sum_ext;

    // Extra top bit captures the carry out of the accumulator.
    always_comb begin
        w_sum_ext = {1'b0, r_acc} + {{(ACC_WIDTH+1-2*DATA_WIDTH){1'b0}}, in_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ACCUM;
                        r_acc   <= '0;
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    // abort wins over a same-cycle product, which is dropped
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (in_valid) begin
                        r_acc   <= w_sum_ext[ACC_WIDTH-1:0];
                        r_count <= r_count + 1'b1;
                        if (w_sum_ext[ACC_WIDTH]) begin
                            r_ovf <= 1'b1;
                        end
                        if (r_count == LAST) begin
                            r_sum       <= w_sum_ext[ACC_WIDTH-1:0];
                            r_sum_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (sum_ready_i) begin
                        r_sum_valid <= 1'b0;
                        if (start) begin
                            r_state <= S_ACCUM;
                            r_acc   <= '0;
                            r_count <= '0;
                            r_ovf   <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_sum_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == S_ACCUM);
    assign busy_o      = (r_state != S_IDLE);
    assign sum_o       = r_sum;
    assign sum_valid_o = r_sum_valid;
    assign overflow_o  = r_ovf;
    assign count_o     = r_count;
    assign o_state     = r_state;

endmodule

// File: tb/tb_muluint_accum.sv
// Bench for muluint_accum: a default-width instance plus a 21-bit accumulator
// instance sharing the same stimulus, with a queue of expected batch sums.
module tb_muluint_accum;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [19:0] in_data;
  logic        in_valid;
  logic        sum_ready_i;

  logic        in_ready;
  logic [23:0] sum_o;
  logic        sum_valid_o;
  logic        overflow_o;
  logic [2:0]  count_o;
  logic        busy_o;
  logic [1:0]  state_o;

  logic        in_ready2;
  logic [20:0] sum2;
  logic        sum_valid2;
  logic        overflow2;
  logic [2:0]  count2;
  logic        busy2;
  logic [1:0]  state2;

  logic [23:0] exp_q[$];
  logic [23:0] exp_v;
  int          checks;
  int          errors;

  muluint_accum dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sum_o(sum_o), .sum_valid_o(sum_valid_o), .sum_ready_i(sum_ready_i),
    .overflow_o(overflow_o), .count_o(count_o), .busy_o(busy_o), .o_state(state_o)
  );

  muluint_accum #(.ACC_WIDTH(21)) dut_ovf (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
    .sum_o(sum2), .sum_valid_o(sum_valid2), .sum_ready_i(sum_ready_i),
    .overflow_o(overflow2), .count_o(count2), .busy_o(busy2), .o_state(state2)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; sum_ready_i = 1'b0;
    step(); step();
    checks++;
    if ({sum_o, sum_valid_o, overflow_o, count_o, busy_o, in_ready, state_o} !== '0) begin
      errors++;
      $display("FAIL reset_init: sum=%0d sv=%b ovf=%b cnt=%0d busy=%b rdy=%b st=%0d, required all 0",
               sum_o, sum_valid_o, overflow_o, count_o, busy_o, in_ready, state_o);
    end
    rst = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1; in_data = 20'd9; step(); step();
    checks++;
    if (count_o !== 3'd2) begin
      errors++; $display("FAIL reset_pre_count: got %0d, required 2", count_o);
    end
    rst = 1'b1; step(); step();
    checks++;
    if ({sum_o, sum_valid_o, overflow_o, count_o, busy_o, in_ready, state_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid_traffic: sum=%0d sv=%b ovf=%b cnt=%0d busy=%b rdy=%b st=%0d, required all 0",
               sum_o, sum_valid_o, overflow_o, count_o, busy_o, in_ready, state_o);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (count_o !== 3'd0 || in_ready !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_valid_ignored: cnt=%0d rdy=%b busy=%b, required 0 0 0", count_o, in_ready, busy_o);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [19:0] prod [4];
    prod[0] = 20'd100; prod[1] = 20'd200; prod[2] = 20'd300; prod[3] = 20'd400;
    sum_ready_i = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy_o !== 1'b1 || count_o !== 3'd0) begin
      errors++; $display("FAIL basic_start: rdy=%b busy=%b cnt=%0d, required 1 1 0", in_ready, busy_o, count_o);
    end
    exp_q.push_back(24'd1000);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sum_valid_o !== 1'b0) begin
        errors++; $display("FAIL basic_early_valid: sum_valid=%b before product %0d, required 0", sum_valid_o, i);
      end
      in_valid = 1'b1; in_data = prod[i]; step();
    end
    in_valid = 1'b0;
    checks++;
    if (sum_valid_o !== 1'b1) begin
      errors++; $display("FAIL basic_valid: sum_valid=%b, required 1", sum_valid_o);
    end else begin
      exp_v = exp_q.pop_front();
      if (sum_o !== exp_v) begin
        errors++; $display("FAIL basic_sum: got %0d, required %0d", sum_o, exp_v);
      end
    end
    checks++;
    if (count_o !== 3'd4 || overflow_o !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL basic_flags: cnt=%0d ovf=%b rdy=%b, required 4 0 0", count_o, overflow_o, in_ready);
    end
    step();
    checks++;
    if (sum_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL basic_drop: sum_valid=%b busy=%b, required 0 0", sum_valid_o, busy_o);
    end
  endtask

  task automatic test_overflow();
    sum_ready_i = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    exp_q.push_back(24'd4186116);
    in_valid = 1'b1; in_data = 20'd1046529;
    for (int i = 0; i < 4; i++) step();
    in_valid = 1'b0;
    checks++;
    if (sum_valid_o !== 1'b1) begin
      errors++; $display("FAIL ovf_wide_valid: sum_valid=%b, required 1", sum_valid_o);
    end else begin
      exp_v = exp_q.pop_front();
      if (sum_o !== exp_v || overflow_o !== 1'b0) begin
        errors++; $display("FAIL ovf_wide_sum: sum=%0d ovf=%b, required %0d 0", sum_o, overflow_o, exp_v);
      end
    end
    checks++;
    if (sum_valid2 !== 1'b1 || sum2 !== 21'd2088964 || overflow2 !== 1'b1) begin
      errors++; $display("FAIL ovf_narrow: sv=%b sum=%0d ovf=%b, required 1 2088964 1", sum_valid2, sum2, overflow2);
    end
    sum_ready_i = 1'b1; step();
    checks++;
    if (overflow2 !== 1'b1 || busy2 !== 1'b0) begin
      errors++; $display("FAIL ovf_sticky: ovf=%b busy=%b, required 1 0", overflow2, busy2);
    end
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (overflow2 !== 1'b0 || in_ready2 !== 1'b1) begin
      errors++; $display("FAIL ovf_clear: ovf=%b rdy=%b, required 0 1", overflow2, in_ready2);
    end
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic test_gaps_backpressure();
    logic [19:0] prod [4];
    prod[0] = 20'd5; prod[1] = 20'd7; prod[2] = 20'd11; prod[3] = 20'd13;
    sum_ready_i = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    exp_q.push_back(24'd36);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = prod[i]; step(); in_valid = 1'b0;
      if (i < 3) begin
        int gap;
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) step();
      end
    end
    checks++;
    if (sum_valid_o !== 1'b1) begin
      errors++; $display("FAIL gaps_valid: sum_valid=%b, required 1", sum_valid_o);
    end else begin
      exp_v = exp_q.pop_front();
      if (sum_o !== exp_v) begin
        errors++; $display("FAIL gaps_sum: got %0d, required %0d", sum_o, exp_v);
      end
    end
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      in_valid = 1'b1; in_data = 20'd99;
      step();
      checks++;
      if (sum_valid_o !== 1'b1 || sum_o !== 24'd36 || in_ready !== 1'b0 || count_o !== 3'd4) begin
        errors++;
        $display("FAIL hold_stable: sv=%b sum=%0d rdy=%b cnt=%0d, required 1 36 0 4", sum_valid_o, sum_o, in_ready, count_o);
      end
    end
    start = 1'b0; in_valid = 1'b0;
    sum_ready_i = 1'b1; start = 1'b1; step(); start = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || count_o !== 3'd0 || sum_valid_o !== 1'b0 || sum_o !== 24'd36) begin
      errors++;
      $display("FAIL hold_restart: rdy=%b cnt=%0d sv=%b sum=%0d, required 1 0 0 36", in_ready, count_o, sum_valid_o, sum_o);
    end
  endtask

  task automatic test_abort();
    in_valid = 1'b1; in_data = 20'd50; step();
    in_data = 20'd60; step();
    abort = 1'b1; in_data = 20'd70; step();
    abort = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy_o !== 1'b0 || count_o !== 3'd2 || sum_o !== 24'd36 || sum_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL abort: rdy=%b busy=%b cnt=%0d sum=%0d sv=%b, required 0 0 2 36 0",
               in_ready, busy_o, count_o, sum_o, sum_valid_o);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (sum_valid_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++; $display("FAIL abort_idle: sv=%b busy=%b, required 0 0", sum_valid_o, busy_o);
      end
    end
  endtask

  task automatic test_reset_mid_batch();
    sum_ready_i = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 20'($urandom_range(1, 1000)); step();
    end
    in_valid = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || count_o !== 3'd0 || sum_o !== 24'd0) begin
      errors++; $display("FAIL rst_mid: busy=%b cnt=%0d sum=%0d, required 0 0 0", busy_o, count_o, sum_o);
    end
    start = 1'b1; step(); start = 1'b0;
    exp_q.push_back(24'd10);
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 20'(i); step();
    end
    in_valid = 1'b0;
    checks++;
    if (sum_valid_o !== 1'b1) begin
      errors++; $display("FAIL rst_fresh_valid: sum_valid=%b, required 1", sum_valid_o);
    end else begin
      exp_v = exp_q.pop_front();
      if (sum_o !== exp_v) begin
        errors++; $display("FAIL rst_fresh_sum: got %0d, required %0d", sum_o, exp_v);
      end
    end
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if (sum_valid_o !== 1'b0 || sum_o !== 24'd0 || busy_o !== 1'b0 || count_o !== 3'd0) begin
      errors++;
      $display("FAIL rst_in_hold: sv=%b sum=%0d busy=%b cnt=%0d, required 0 0 0 0", sum_valid_o, sum_o, busy_o, count_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] prod [4];
    logic [23:0] acc;
    sum_ready_i = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      acc = '0;
      for (int i = 0; i < 4; i++) begin
        prod[i] = 20'($urandom_range(0, 1046529));
        acc = acc + {4'd0, prod[i]};
      end
      exp_q.push_back(acc);
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        in_data = prod[i]; step();
      end
      in_valid = 1'b0;
      checks++;
      if (sum_valid_o !== 1'b1 || count_o !== 3'd4) begin
        errors++; $display("FAIL b2b_valid: batch %0d sv=%b cnt=%0d, required 1 4", b, sum_valid_o, count_o);
      end else begin
        exp_v = exp_q.pop_front();
        if (sum_o !== exp_v) begin
          errors++; $display("FAIL b2b_sum: batch %0d got %0d, required %0d", b, sum_o, exp_v);
        end
      end
      sum_ready_i = 1'b1; start = (b < 2); step(); start = 1'b0; sum_ready_i = 1'b0;
      checks++;
      if (in_ready !== (b < 2) || sum_valid_o !== 1'b0 || count_o !== ((b < 2) ? 3'd0 : 3'd4)) begin
        errors++;
        $display("FAIL b2b_next: batch %0d rdy=%b sv=%b cnt=%0d, required %b 0 %0d",
                 b, in_ready, sum_valid_o, count_o, (b < 2), (b < 2) ? 0 : 4);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_gaps_backpressure();
    test_abort();
    test_reset_mid_batch();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d expected sums left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
